// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: arbiter states and memType (funct3) codes.
// Pure declarations; no timing or backpressure behaviour of its own.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_REQ_I  = 3'd1,
    ARB_REQ_D  = 3'd2,
    ARB_WAIT_I = 3'd3,
    ARB_WAIT_D = 3'd4
  } arb_state_e;

  localparam logic [2:0] MT_LB  = 3'b000;
  localparam logic [2:0] MT_LH  = 3'b001;
  localparam logic [2:0] MT_LW  = 3'b010;
  localparam logic [2:0] MT_LD  = 3'b011;
  localparam logic [2:0] MT_LBU = 3'b100;
  localparam logic [2:0] MT_LHU = 3'b101;
  localparam logic [2:0] MT_LWU = 3'b110;

  // STARVE_MAX is limited to 1..15, so four bits always suffice.
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of data grants that were taken while fetch was waiting; clear has priority.
// Registered count, so at_max_o reflects grants made in earlier cycles only.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [STARVE_CNT_W-1:0] MAX_V = STARVE_CNT_W'(MAX);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction at a time.
// Grant is combinational, m_* follow one cycle later; m_ready stalls REQ_x, responses pass straight through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MTYPE_W    = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               if_kill,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [31:0]        if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [MTYPE_W-1:0] d_type,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               m_req,
  output logic               m_we,
  output logic [MTYPE_W-1:0] m_type,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_wdata,
  input  logic               m_ready,
  input  logic               m_rvalid,
  input  logic [DATA_W-1:0]  m_rdata,
  output logic               busy,
  output logic               protocol_err
);

  arb_state_e         state_q, state_d;
  logic               m_we_q, m_we_d;
  logic [MTYPE_W-1:0] m_type_q, m_type_d;
  logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
  logic               kill_q, kill_d;
  logic               perr_q, perr_d;

  logic in_wait, resp, arb_en, fetch_win, data_win, fetch_own, starve_max;

  assign in_wait   = (state_q == ARB_WAIT_I) || (state_q == ARB_WAIT_D);
  assign resp      = in_wait && m_rvalid;
  // Reset gates arbitration so no grant can leak out while reset is held.
  assign arb_en    = reset && ((state_q == ARB_IDLE) || resp);
  assign fetch_win = arb_en && if_req && !if_kill && (!d_req || starve_max);
  assign data_win  = arb_en && d_req && !fetch_win;
  assign fetch_own = (state_q == ARB_REQ_I) || (state_q == ARB_WAIT_I);

  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (!if_req || fetch_win),
    .inc_i    (data_win && if_req),
    .at_max_o (starve_max)
  );

  always_comb begin
    state_d   = state_q;
    m_we_d    = m_we_q;
    m_type_d  = m_type_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    kill_d    = kill_q;
    perr_d    = perr_q || (m_rvalid && !in_wait);

    case (state_q)
      ARB_IDLE:   ;
      ARB_REQ_I:  if (m_ready) state_d = ARB_WAIT_I;
      ARB_REQ_D:  if (m_ready) state_d = ARB_WAIT_D;
      ARB_WAIT_I,
      ARB_WAIT_D: if (m_rvalid) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase

    // A grant in the response cycle overrides the return to IDLE.
    if (fetch_win) begin
      state_d   = ARB_REQ_I;
      m_we_d    = 1'b0;
      m_type_d  = MTYPE_W'(MT_LW);
      m_addr_d  = if_addr;
      m_wdata_d = '0;
    end else if (data_win) begin
      state_d   = ARB_REQ_D;
      m_we_d    = d_we;
      m_type_d  = d_type;
      m_addr_d  = d_addr;
      m_wdata_d = d_wdata;
    end

    if ((state_q == ARB_WAIT_I) && m_rvalid) begin
      kill_d = 1'b0;
    end else if (if_kill && fetch_own) begin
      kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      m_we_q    <= 1'b0;
      m_type_q  <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      kill_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_we_q    <= m_we_d;
      m_type_q  <= m_type_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      kill_q    <= kill_d;
      perr_q    <= perr_d;
    end
  end

  assign if_gnt       = fetch_win;
  assign d_gnt        = data_win;
  assign m_req        = (state_q == ARB_REQ_I) || (state_q == ARB_REQ_D);
  assign m_we         = m_we_q;
  assign m_type       = m_type_q;
  assign m_addr       = m_addr_q;
  assign m_wdata      = m_wdata_q;
  assign busy         = (state_q != ARB_IDLE);
  assign protocol_err = perr_q;

  // A kill arriving in the response cycle itself still suppresses that response.
  assign if_rvalid = (state_q == ARB_WAIT_I) && m_rvalid && !kill_q && !if_kill;
  assign d_rvalid  = (state_q == ARB_WAIT_D) && m_rvalid;
  assign d_rdata   = reset ? m_rdata : '0;
  assign if_rdata  = !reset ? 32'h0 : (m_addr_q[2] ? m_rdata[32 +: 32] : m_rdata[0 +: 32]);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter; inputs change 1 time unit after the rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, if_gnt, if_rvalid;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]  d_type;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [2:0]  m_type;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        busy, protocol_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MTYPE_W(3), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_type(m_type), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .protocol_err(protocol_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b1; if_kill = 1'b0; if_addr = 64'h40;
    d_req = 1'b1; d_we = 1'b1; d_type = 3'b011; d_addr = 64'h100; d_wdata = 64'h55;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, m_we, busy, protocol_err} !== 8'h00) begin
      n_bad++; $display("FAIL rst_ctrl: got %b want 00000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, m_we, busy, protocol_err}); end
    n_cmp++; if ({m_addr, m_wdata, m_type} !== 131'h0) begin
      n_bad++; $display("FAIL rst_mbus: got addr %h wdata %h type %b want 0", m_addr, m_wdata, m_type); end
    n_cmp++; if ({if_rdata, d_rdata} !== 96'h0) begin
      n_bad++; $display("FAIL rst_rdata: got if %h d %h want 0", if_rdata, d_rdata); end
    reset = 1'b1; #1;
    n_cmp++; if ({if_gnt, d_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL rel_gnt: got if/d %b want 01", {if_gnt, d_gnt}); end
    cyc(); d_req = 1'b0; if_req = 1'b0; m_ready = 1'b1; m_rdata = 64'h0; #1;
    n_cmp++; if ({m_req, m_we, m_type, m_addr, m_wdata, busy} !== {1'b1, 1'b1, 3'b011, 64'h100, 64'h55, 1'b1}) begin
      n_bad++; $display("FAIL rel_reqd: got req %b we %b type %b addr %h wdata %h", m_req, m_we, m_type, m_addr, m_wdata); end
    cyc(); m_ready = 1'b0; #1;
    n_cmp++; if ({m_req, busy} !== 2'b01) begin
      n_bad++; $display("FAIL rel_waitd: got req/busy %b want 01", {m_req, busy}); end
    cyc(); m_rvalid = 1'b1; m_rdata = 64'h1234; #1;
    n_cmp++; if ({d_rvalid, if_rvalid, d_rdata} !== {1'b1, 1'b0, 64'h1234}) begin
      n_bad++; $display("FAIL rel_resp: got d_rv %b if_rv %b d_rdata %h want 1 0 1234", d_rvalid, if_rvalid, d_rdata); end
    cyc(); m_rvalid = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL rel_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_fetch_only();
    cyc(); if_req = 1'b1; if_addr = 64'h1004; #1;
    n_cmp++; if ({if_gnt, d_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL fo_gnt: got if/d %b want 10", {if_gnt, d_gnt}); end
    cyc(); if_req = 1'b0; if_addr = 64'h0; m_ready = 1'b1; #1;
    n_cmp++; if ({m_req, m_we, m_type, m_addr} !== {1'b1, 1'b0, 3'b010, 64'h1004}) begin
      n_bad++; $display("FAIL fo_req: got req %b we %b type %b addr %h want 1 0 010 1004", m_req, m_we, m_type, m_addr); end
    cyc(); m_ready = 1'b0; #1;
    cyc();
    m_rvalid = 1'b1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    n_cmp++; if ({if_rvalid, if_rdata, busy} !== {1'b1, 32'hAAAABBBB, 1'b1}) begin
      n_bad++; $display("FAIL fo_resp: got rv %b rdata %h busy %b want 1 aaaabbbb 1", if_rvalid, if_rdata, busy); end
    cyc(); m_rvalid = 1'b0; #1;
    n_cmp++; if ({busy, if_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL fo_idle: got busy/rv %b want 00", {busy, if_rvalid}); end
  endtask

  task automatic test_contention();
    cyc(); if_req = 1'b1; if_addr = 64'h3000;
    d_req = 1'b1; d_we = 1'b1; d_type = 3'b011; d_addr = 64'h2000; d_wdata = 64'hDEAD; #1;
    n_cmp++; if ({if_gnt, d_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL ct_gnt: got if/d %b want 01", {if_gnt, d_gnt}); end
    cyc(); d_req = 1'b0; m_ready = 1'b1; #1;
    n_cmp++; if ({m_req, m_we, m_addr, m_wdata, if_gnt} !== {1'b1, 1'b1, 64'h2000, 64'hDEAD, 1'b0}) begin
      n_bad++; $display("FAIL ct_store: got req %b we %b addr %h wdata %h if_gnt %b", m_req, m_we, m_addr, m_wdata, if_gnt); end
    cyc(); m_ready = 1'b0; #1;
    cyc(); m_rvalid = 1'b1; m_rdata = 64'h0; #1;
    n_cmp++; if ({d_rvalid, if_gnt} !== 2'b11) begin
      n_bad++; $display("FAIL ct_regnt: got d_rv/if_gnt %b want 11", {d_rvalid, if_gnt}); end
    cyc(); m_rvalid = 1'b0; if_req = 1'b0; #1;
    n_cmp++; if ({m_req, m_we, m_type, m_addr} !== {1'b1, 1'b0, 3'b010, 64'h3000}) begin
      n_bad++; $display("FAIL ct_freq: got req %b we %b type %b addr %h want 1 0 010 3000", m_req, m_we, m_type, m_addr); end
    m_ready = 1'b1;
    cyc(); m_ready = 1'b0;
    cyc(); m_rvalid = 1'b1; m_rdata = 64'h1111_1111_2222_2222; #1;
    n_cmp++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h22222222}) begin
      n_bad++; $display("FAIL ct_fresp: got rv %b rdata %h want 1 22222222", if_rvalid, if_rdata); end
    cyc(); m_rvalid = 1'b0; #1;
  endtask

  task automatic test_starvation();
    logic [1:0] exp;
    cyc(); if_req = 1'b1; if_addr = 64'h4000;
    d_req = 1'b1; d_we = 1'b0; d_type = 3'b011; d_addr = 64'h5000; #1;
    for (int k = 0; k <= 6; k++) begin
      exp = (k == 4) ? 2'b10 : 2'b01;
      n_cmp++; if ({if_gnt, d_gnt} !== exp) begin
        n_bad++; $display("FAIL sv_gnt%0d: got if/d %b want %b", k, {if_gnt, d_gnt}, exp); end
      if (k == 6) break;
      cyc(); m_rvalid = 1'b0; m_ready = 1'b1; #1;
      cyc(); m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'(k); #1;
      if (exp == 2'b10) begin
        n_cmp++; if ({if_rvalid, d_rvalid, if_rdata} !== {1'b1, 1'b0, 32'd4}) begin
          n_bad++; $display("FAIL sv_ifresp: got if_rv %b d_rv %b rdata %h want 1 0 4", if_rvalid, d_rvalid, if_rdata); end
      end else begin
        n_cmp++; if ({d_rvalid, if_rvalid, d_rdata} !== {1'b1, 1'b0, 64'(k)}) begin
          n_bad++; $display("FAIL sv_dresp%0d: got d_rv %b if_rv %b rdata %h", k, d_rvalid, if_rvalid, d_rdata); end
      end
    end
    if_req = 1'b0; d_req = 1'b0; #1;
    cyc(); m_rvalid = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL sv_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_kill();
    cyc(); if_req = 1'b1; if_addr = 64'h6000; #1;
    n_cmp++; if (if_gnt !== 1'b1) begin
      n_bad++; $display("FAIL kl_gnt: got %b want 1", if_gnt); end
    cyc(); if_req = 1'b0; m_ready = 1'b1;
    cyc(); m_ready = 1'b0; if_kill = 1'b1; #1;
    cyc(); if_kill = 1'b0; d_req = 1'b1; d_we = 1'b0; d_type = 3'b011; d_addr = 64'h7000; #1;
    n_cmp++; if (d_gnt !== 1'b0) begin
      n_bad++; $display("FAIL kl_nogntwait: got d_gnt %b want 0", d_gnt); end
    cyc(); m_rvalid = 1'b1; m_rdata = 64'hCAFE; #1;
    n_cmp++; if ({if_rvalid, d_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL kl_resp: got if_rv/d_gnt %b want 01", {if_rvalid, d_gnt}); end
    cyc(); m_rvalid = 1'b0; d_req = 1'b0; m_ready = 1'b1; #1;
    n_cmp++; if ({m_req, m_addr} !== {1'b1, 64'h7000}) begin
      n_bad++; $display("FAIL kl_dreq: got req %b addr %h want 1 7000", m_req, m_addr); end
    cyc(); m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hBEEF; #1;
    n_cmp++; if ({d_rvalid, d_rdata} !== {1'b1, 64'hBEEF}) begin
      n_bad++; $display("FAIL kl_dresp: got rv %b rdata %h want 1 beef", d_rvalid, d_rdata); end
    cyc(); m_rvalid = 1'b0; if_req = 1'b1; if_kill = 1'b1; if_addr = 64'h6004; #1;
    n_cmp++; if (if_gnt !== 1'b0) begin
      n_bad++; $display("FAIL kl_arbkill: got if_gnt %b want 0", if_gnt); end
    if_kill = 1'b0; #1;
    n_cmp++; if (if_gnt !== 1'b1) begin
      n_bad++; $display("FAIL kl_regnt: got if_gnt %b want 1", if_gnt); end
    cyc(); if_req = 1'b0; m_ready = 1'b1;
    cyc(); m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h9999_8888_7777_6666; #1;
    n_cmp++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h99998888}) begin
      n_bad++; $display("FAIL kl_after: got rv %b rdata %h want 1 99998888", if_rvalid, if_rdata); end
    cyc(); m_rvalid = 1'b0; #1;
  endtask

  task automatic test_protocol_reset();
    cyc(); m_rvalid = 1'b1; m_rdata = 64'h77; #1;
    n_cmp++; if ({d_rvalid, if_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL pe_norv: got d/if rv %b want 00", {d_rvalid, if_rvalid}); end
    cyc(); m_rvalid = 1'b0; #1;
    n_cmp++; if (protocol_err !== 1'b1) begin
      n_bad++; $display("FAIL pe_set: got %b want 1", protocol_err); end
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000; #1;
    n_cmp++; if ({protocol_err, d_gnt} !== 2'b11) begin
      n_bad++; $display("FAIL pe_sticky: got perr/d_gnt %b want 11", {protocol_err, d_gnt}); end
    cyc(); d_req = 1'b0; m_ready = 1'b1;
    cyc(); m_ready = 1'b0; #1;
    n_cmp++; if (busy !== 1'b1) begin
      n_bad++; $display("FAIL pe_waitd: got busy %b want 1", busy); end
    reset = 1'b0; m_rvalid = 1'b1; #1;
    n_cmp++; if ({busy, protocol_err, d_rvalid, m_req, m_addr} !== {4'b0000, 64'h0}) begin
      n_bad++; $display("FAIL pe_rst: got busy %b perr %b d_rv %b req %b addr %h", busy, protocol_err, d_rvalid, m_req, m_addr); end
    cyc(); reset = 1'b1; m_rvalid = 1'b0; #1;
    n_cmp++; if ({busy, protocol_err, d_rvalid} !== 3'b000) begin
      n_bad++; $display("FAIL pe_post: got busy/perr/d_rv %b want 000", {busy, protocol_err, d_rvalid}); end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_contention();
    test_starvation();
    test_kill();
    test_protocol_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
